// File: rtl/pulse_filter_pkg.sv
// Shared types and constants for the pulse_filter glitch filter / edge detector.
package pulse_filter_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_RISE_CHK = 2'd1,
        S_HIGH     = 2'd2,
        S_FALL_CHK = 2'd3
    } pf_state_t;

    // Depth of the metastability synchroniser in front of the filter.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pulse_filter_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous raw level into the clk domain.
module sync_2ff
    import pulse_filter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw level through the flop chain; chain[0] is ff1, chain[1] is ff2.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pulse_filter.sv
// pulse_filter: synchronises a raw level, accepts a new level only after it has
// been stable for STABLE_CYCLES clocks, and emits registered rise/fall strobes
// plus a wrapping rise count.
// Optional build macro PULSE_WIDTH_MEAS_EN adds a saturating high-time measurement
// reported on width/width_valid; without it those ports are tied to 0.
module pulse_filter
    import pulse_filter_pkg::*;
#(
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W         = 8,
    parameter int WIDTH_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    output logic               out,
    output logic               rise,
    output logic               fall,
    output logic [CNT_W-1:0]   edge_cnt,
    output logic [WIDTH_W-1:0] width,
    output logic               width_valid
);

    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_TARGET = SC_W'(STABLE_CYCLES);
    localparam logic [SC_W-1:0] SC_ONE    = SC_W'(1);

    logic            sync_in;
    pf_state_t       state, state_nxt;
    logic [SC_W-1:0] stab_cnt, stab_nxt, stab_inc;
    logic            rise_nxt, fall_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (sync_in)
    );

    // Next-state logic: a candidate level must survive STABLE_CYCLES samples to be accepted.
    always_comb begin
        state_nxt = state;
        stab_nxt  = stab_cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        stab_inc  = stab_cnt + 1'b1;
        case (state)
            S_LOW: begin
                if (sync_in) begin
                    if (STABLE_CYCLES == 1) begin
                        state_nxt = S_HIGH;
                        rise_nxt  = 1'b1;
                        stab_nxt  = '0;
                    end else begin
                        state_nxt = S_RISE_CHK;
                        stab_nxt  = SC_ONE;
                    end
                end
            end
            S_RISE_CHK: begin
                if (!sync_in) begin
                    state_nxt = S_LOW;
                    stab_nxt  = '0;
                end else if (stab_inc == SC_TARGET) begin
                    state_nxt = S_HIGH;
                    rise_nxt  = 1'b1;
                    stab_nxt  = '0;
                end else begin
                    stab_nxt  = stab_inc;
                end
            end
            S_HIGH: begin
                if (!sync_in) begin
                    if (STABLE_CYCLES == 1) begin
                        state_nxt = S_LOW;
                        fall_nxt  = 1'b1;
                        stab_nxt  = '0;
                    end else begin
                        state_nxt = S_FALL_CHK;
                        stab_nxt  = SC_ONE;
                    end
                end
            end
            S_FALL_CHK: begin
                if (sync_in) begin
                    state_nxt = S_HIGH;
                    stab_nxt  = '0;
                end else if (stab_inc == SC_TARGET) begin
                    state_nxt = S_LOW;
                    fall_nxt  = 1'b1;
                    stab_nxt  = '0;
                end else begin
                    stab_nxt  = stab_inc;
                end
            end
            default: begin
                state_nxt = S_LOW;
                stab_nxt  = '0;
            end
        endcase
    end

    // State, stability counter, registered strobes and rise counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_LOW;
            stab_cnt <= '0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            edge_cnt <= '0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_nxt;
            rise     <= rise_nxt;
            fall     <= fall_nxt;
            if (rise_nxt) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

    // Filtered level: high while accepted high, including while a fall is being qualified.
    assign out = (state == S_HIGH) || (state == S_FALL_CHK);

`ifdef PULSE_WIDTH_MEAS_EN
    localparam logic [WIDTH_W-1:0] W_MAX = '1;

    logic [WIDTH_W-1:0] wcnt;
    logic               out_nxt;

    function automatic logic [WIDTH_W-1:0] sat_inc(input logic [WIDTH_W-1:0] v);
        return (v == W_MAX) ? v : v + 1'b1;
    endfunction

    assign out_nxt = (state_nxt == S_HIGH) || (state_nxt == S_FALL_CHK);

    // Count cycles out is high (rise cycle is 1) and publish the count on the fall strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt        <= '0;
            width       <= '0;
            width_valid <= 1'b0;
        end else begin
            width_valid <= fall_nxt;
            if (fall_nxt) begin
                width <= wcnt;
            end
            if (rise_nxt) begin
                wcnt <= WIDTH_W'(1);
            end else if (out_nxt) begin
                wcnt <= sat_inc(wcnt);
            end
        end
    end
`else
    assign width       = '0;
    assign width_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_filter.sv
// Directed bench for pulse_filter: a wide-counter instance and a narrow
// (CNT_W=2, WIDTH_W=3) instance share one input; expected strobes are queued
// as stimulus is driven and matched when the strobes appear.
module tb_pulse_filter;

    typedef struct {
        bit is_rise;
        int cyc;
        int cnt;
        int len;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in;
    logic       out,  rise,  fall,  wv;
    logic [7:0] cnt8, w8;
    logic       out2, rise2, fall2, wv2;
    logic [1:0] cnt2;
    logic [2:0] w3;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   exp_rises = 0;
    exp_t q[$];

    pulse_filter #(.STABLE_CYCLES(3), .CNT_W(8), .WIDTH_W(8)) dut (
        .clk(clk), .rst(rst), .in(in), .out(out), .rise(rise), .fall(fall),
        .edge_cnt(cnt8), .width(w8), .width_valid(wv)
    );

    pulse_filter #(.STABLE_CYCLES(3), .CNT_W(2), .WIDTH_W(3)) dut2 (
        .clk(clk), .rst(rst), .in(in), .out(out2), .rise(rise2), .fall(fall2),
        .edge_cnt(cnt2), .width(w3), .width_valid(wv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int wexp(input int len, input int wbits);
`ifdef PULSE_WIDTH_MEAS_EN
        int m;
        m = (1 << wbits) - 1;
        return (len > m) ? m : len;
`else
        return 0;
`endif
    endfunction

    function automatic int wvexp();
`ifdef PULSE_WIDTH_MEAS_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_rise(input int at);
        exp_t e;
        exp_rises++;
        e.is_rise = 1'b1; e.cyc = at; e.cnt = exp_rises; e.len = 0;
        q.push_back(e);
    endtask

    task automatic push_fall(input int at, input int len);
        exp_t e;
        e.is_rise = 1'b0; e.cyc = at; e.cnt = exp_rises; e.len = len;
        q.push_back(e);
    endtask

    // Clean pulse of len clocks followed by gap clocks low.
    task automatic pulse(input int len, input int gap);
        int n;
        n = cyc;
        push_rise(n + 5);
        in = 1'b1;
        tick(len);
        push_fall(n + len + 5, len);
        in = 1'b0;
        tick(gap);
    endtask

    // Match every strobe against the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rise || fall || wv || rise2 || fall2 || wv2) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", {26'd0, rise, fall, wv, rise2, fall2, wv2}, 0);
            end else begin
                e = q.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("rise", rise, e.is_rise);
                check("fall", fall, !e.is_rise);
                check("rise_n", rise2, e.is_rise);
                check("fall_n", fall2, !e.is_rise);
                check("out", out, e.is_rise);
                if (e.is_rise) begin
                    check("edge_cnt", cnt8, e.cnt % 256);
                    check("edge_cnt_n", cnt2, e.cnt % 4);
                    check("wv_on_rise", wv, 0);
                end else begin
                    check("width", w8, wexp(e.len, 8));
                    check("width_n", w3, wexp(e.len, 3));
                    check("width_valid", wv, wvexp());
                    check("width_valid_n", wv2, wvexp());
                end
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        in  = 1'b1;

        // Reset held two clocks with in high: everything stays clear.
        repeat (2) begin
            tick(1);
            check("rst_out", out, 0);
            check("rst_rise", rise, 0);
            check("rst_fall", fall, 0);
            check("rst_cnt", cnt8, 0);
            check("rst_width", w8, 0);
            check("rst_wv", wv, 0);
        end

        // Release with in still high: rise five edges after release, held 8 clocks.
        rst = 1'b0;
        n = cyc;
        push_rise(n + 5);
        tick(8);
        push_fall(n + 8 + 5, 8);
        in = 1'b0;
        tick(10);

        // Plain 8-clock pulse.
        pulse(8, 10);

        // 2-clock high glitch is rejected.
        in = 1'b1;
        tick(2);
        in = 1'b0;
        tick(8);
        check("glitch_out", out, 0);
        check("glitch_cnt", cnt8, exp_rises);

        // 2-clock low dip inside a high pulse does not split it.
        n = cyc;
        push_rise(n + 5);
        in = 1'b1;
        tick(8);
        in = 1'b0;
        tick(2);
        in = 1'b1;
        tick(8);
        push_fall(n + 18 + 5, 18);
        in = 1'b0;
        tick(10);

        // Reset while qualifying a rise (stab_cnt=2) discards the partial count.
        in = 1'b1;
        tick(4);
        rst = 1'b1;
        in  = 1'b0;
        exp_rises = 0;
        tick(1);
        check("mid_rst_out", out, 0);
        check("mid_rst_cnt", cnt8, 0);
        check("mid_rst_cnt_n", cnt2, 0);
        rst = 1'b0;
        in  = 1'b1;
        tick(2);
        in  = 1'b0;
        tick(8);
        check("post_rst_out", out, 0);
        check("post_rst_cnt", cnt8, 0);
        // Exactly STABLE_CYCLES clocks high is accepted.
        pulse(3, 8);

        // Counter wrap on the narrow instance: 1,2,3,0,1.
        rst = 1'b1;
        exp_rises = 0;
        tick(1);
        rst = 1'b0;
        repeat (5) pulse(6, 6);
        tick(4);

        // Width measurement, including 3-bit saturation on a 12-clock pulse.
        pulse(10, 8);
        pulse(12, 8);

        tick(20);
        check("queue_drained", q.size(), 0);
        check("final_out", out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
